fetch_stage: RTL and testbench

Instruction-fetch stage (pipeline stage 1) that produces the `if_id_pc` / `if_id_instr` pair consumed by the decode stage, and accepts its `stall` and branch-redirect (`b_taken`, `b_pc`) signals in return. It keeps the program counter and issues one instruction-memory request at a time. Fetched words are buffered in a small FIFO so that a stalled decode stage does not lose fetched instructions. Stale responses that follow a redirect are discarded.

---
 rtl/fetch_stage_pkg.sv | 18 +
 rtl/fetch_fifo.sv | 48 ++++
 rtl/fetch_stage.sv | 128 ++++++++++++
 tb/tb_fetch_stage.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared constants and types for the instruction-fetch stage.
package fetch_stage_pkg;

  localparam logic [31:0] BOOT_ADDRESS = 32'h0000_1000;
  localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;  // addi x0,x0,0

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_word_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small power-of-two FIFO of {pc, instr} words; flush empties it in one cycle.
module fetch_fifo
  import fetch_stage_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      push,
  input  logic                      pop,
  input  fetch_word_t               wdata,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      empty,
  output fetch_word_t               head
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = AW'(0) + (AW+1)'(DEPTH);

  fetch_word_t   mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic          do_push, do_pop;

  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push && ((count != FULL) || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // NOTE: storage has no reset; occupancy is tracked by the pointers and count,
  // so stale entries are never observed and the array can map to plain RAM/flops.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: one outstanding imem request, credit-checked against
// a small FIFO so a stalled decode stage never loses a fetched word.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] BOOT_ADDR = BOOT_ADDRESS,
  parameter int          DEPTH     = 2,
  parameter logic [31:0] NOP       = NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        b_taken,
  input  logic [31:0] b_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_instr,
  output logic        if_id_valid
);
  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_e  state;
  logic [31:0]   pc, target, next_pc;
  logic [CW-1:0] fifo_count;
  logic [CW:0]   committed;
  logic          fifo_empty, fifo_push, fifo_pop, landing, credit_ok;
  fetch_word_t   fifo_head, ack_word;

  assign target   = b_pc & 32'hFFFF_FFFC;
  assign next_pc  = pc + 32'd4;
  assign ack_word = {imem_addr, imem_rdata};
  assign landing  = (state == S_WAIT) && imem_ack && !b_taken;

  // Words already owed a slot: the FIFO plus a held if_id word that may back up.
  assign committed = {1'b0, fifo_count} + (CW+1)'(if_id_valid & stall);
  assign credit_ok = committed < (CW+1)'(DEPTH);

  assign fifo_pop  = !b_taken && !stall && !fifo_empty;
  assign fifo_push = landing && (stall || !fifo_empty);

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (b_taken),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (ack_word),
    .count (fifo_count),
    .empty (fifo_empty),
    .head  (fifo_head)
  );

  // NOTE: every register here uses non-blocking assignment so all of them
  // update from the same pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      pc          <= BOOT_ADDR;
      imem_req    <= 1'b0;
      imem_addr   <= BOOT_ADDR;
      if_id_pc    <= BOOT_ADDR;
      if_id_instr <= NOP;
      if_id_valid <= 1'b0;
    end else begin
      if (b_taken) begin
        if_id_valid <= 1'b0;
        if_id_instr <= NOP;
      end else if (!stall) begin
        if (!fifo_empty) begin
          if_id_pc    <= fifo_head.pc;
          if_id_instr <= fifo_head.instr;
          if_id_valid <= 1'b1;
        end else if (landing) begin
          if_id_pc    <= imem_addr;
          if_id_instr <= imem_rdata;
          if_id_valid <= 1'b1;
        end else begin
          if_id_instr <= NOP;
          if_id_valid <= 1'b0;
        end
      end

      if (b_taken)      pc <= target;
      else if (landing) pc <= next_pc;

      // The request slot frees on an ack; the next request goes out at once
      // when credit allows, otherwise the FSM parks in S_IDLE.
      case (state)
        S_IDLE: begin
          if (b_taken || credit_ok) begin
            state     <= S_WAIT;
            imem_req  <= 1'b1;
            imem_addr <= b_taken ? target : pc;
          end
        end
        S_WAIT: begin
          if (imem_ack && (b_taken || !credit_ok)) begin
            state    <= S_IDLE;
            imem_req <= 1'b0;
          end else if (imem_ack) begin
            imem_addr <= next_pc;
          end else if (b_taken) begin
            state <= S_DROP;
          end
        end
        S_DROP: begin
          if (imem_ack) begin
            if (b_taken || credit_ok) begin
              state     <= S_WAIT;
              imem_addr <= b_taken ? target : pc;
            end else begin
              state    <= S_IDLE;
              imem_req <= 1'b0;
            end
          end
        end
        default: begin
          state    <= S_IDLE;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: queue-based reference model, variable
// latency memory, directed scenarios followed by randomized traffic.
module tb_fetch_stage;
  localparam int          DEPTH = 2;
  localparam logic [31:0] BOOT  = 32'h0000_1000;
  localparam logic [31:0] NOPW  = 32'h0000_0013;
  localparam logic [31:0] XORK  = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst, stall, b_taken, imem_ack;
  logic [31:0] b_pc, imem_rdata;
  logic        imem_req, if_id_valid;
  logic [31:0] imem_addr, if_id_pc, if_id_instr;

  fetch_stage #(.BOOT_ADDR(BOOT), .DEPTH(DEPTH), .NOP(NOPW)) dut (
    .clk(clk), .rst(rst), .stall(stall), .b_taken(b_taken), .b_pc(b_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .if_id_pc(if_id_pc), .if_id_instr(if_id_instr),
    .if_id_valid(if_id_valid)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // memory responder
  logic        mem_busy = 1'b0;
  int          mem_wait = 0;
  int          mem_lat  = 1;
  logic        mem_rand = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] req_log[$];

  // reference model: request slot, pending PC, FIFO queue, presented word
  logic        m_out = 1'b0, m_drop = 1'b0, m_if_v = 1'b0;
  logic [31:0] m_pc = BOOT, m_addr = BOOT, m_if_pc = BOOT, m_if_instr = NOPW;
  logic [63:0] m_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic compare_model();
    check("imem_req", 32'(imem_req), 32'(m_out));
    if (m_out) check("imem_addr", imem_addr, m_addr);
    check("if_id_valid", 32'(if_id_valid), 32'(m_if_v));
    check("if_id_instr", if_id_instr, m_if_instr);
    check("if_id_pc", if_id_pc, m_if_pc);
  endtask

  // Apply one cycle of inputs, advance the model, then compare after the edge.
  task automatic cycle(input logic s, input logic bt, input logic [31:0] bp, input logic r);
    logic        ack, credit, landing;
    logic [31:0] target;
    logic [63:0] word, head;
    stall = s; b_taken = bt; b_pc = bp; rst = r;

    ack = 1'b0;
    if (r) begin
      mem_busy = 1'b0;
    end else if (mem_busy) begin
      check("imem_addr_stable", imem_addr, mem_addr);
      if (mem_wait == 0) begin ack = 1'b1; mem_busy = 1'b0; end
      else mem_wait--;
    end else if (imem_req === 1'b1) begin
      mem_busy = 1'b1;
      mem_addr = imem_addr;
      mem_wait = (mem_rand ? int'($urandom_range(4, 1)) : mem_lat) - 1;
      req_log.push_back(imem_addr);
    end
    imem_ack   = ack;
    imem_rdata = ack ? (mem_addr ^ XORK) : $urandom();

    if (r) begin
      m_out = 1'b0; m_drop = 1'b0; m_pc = BOOT; m_addr = BOOT;
      m_q.delete(); m_if_pc = BOOT; m_if_instr = NOPW; m_if_v = 1'b0;
    end else begin
      target  = bp & 32'hFFFF_FFFC;
      credit  = (m_q.size() + ((m_if_v && s) ? 1 : 0)) < DEPTH;
      landing = m_out && !m_drop && ack && !bt;
      word    = {m_addr, m_addr ^ XORK};

      if (bt) begin
        m_q.delete(); m_if_v = 1'b0; m_if_instr = NOPW;
      end else if (!s) begin
        if (m_q.size() > 0) begin
          head = m_q.pop_front();
          m_if_pc = head[63:32]; m_if_instr = head[31:0]; m_if_v = 1'b1;
          if (landing) m_q.push_back(word);
        end else if (landing) begin
          m_if_pc = word[63:32]; m_if_instr = word[31:0]; m_if_v = 1'b1;
        end else begin
          m_if_v = 1'b0; m_if_instr = NOPW;
        end
      end else if (landing) begin
        m_q.push_back(word);
      end

      if (!m_out) begin
        if (bt) begin m_pc = target; m_out = 1'b1; m_addr = target; end
        else if (credit) begin m_out = 1'b1; m_addr = m_pc; end
      end else if (!m_drop) begin
        if (bt) begin
          m_pc = target;
          if (ack) m_out = 1'b0; else m_drop = 1'b1;
        end else if (ack) begin
          m_pc = m_pc + 32'd4;
          if (credit) m_addr = m_pc; else m_out = 1'b0;
        end
      end else begin
        if (bt) m_pc = target;
        if (ack) begin
          m_drop = 1'b0;
          if (bt || credit) m_addr = m_pc; else m_out = 1'b0;
        end
      end
    end

    @(posedge clk);
    #1;
    compare_model();
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 40 && imem_req; i++) cycle(1'b1, 1'b0, 32'h0, 1'b0);
    check(name, 32'(imem_req), 32'd0);
  endtask

  initial begin
    int          n0;
    logic        got;
    logic [31:0] last;
    stall = 0; b_taken = 0; b_pc = 0; rst = 1; imem_ack = 0; imem_rdata = 0;

    repeat (3) cycle(1'b0, 1'b0, 32'h0, 1'b1);
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_pc", if_id_pc, 32'h0000_1000);
    check("rst_instr", if_id_instr, 32'h0000_0013);
    check("rst_valid", 32'(if_id_valid), 32'd0);

    // boot fetch, 1-cycle memory
    mem_lat = 1;
    cycle(1'b0, 1'b0, 32'h0, 1'b0);
    check("boot_req", 32'(imem_req), 32'd1);
    check("boot_addr", imem_addr, 32'h0000_1000);
    cycle(1'b0, 1'b0, 32'h0, 1'b0);
    check("boot_valid_early", 32'(if_id_valid), 32'd0);
    cycle(1'b0, 1'b0, 32'h0, 1'b0);
    check("boot_valid", 32'(if_id_valid), 32'd1);
    check("boot_if_pc", if_id_pc, 32'h0000_1000);
    check("boot_if_instr", if_id_instr, 32'hA5A5_1000);

    // stall 10 cycles: if_id frozen, exactly DEPTH further requests
    n0 = req_log.size();
    repeat (10) cycle(1'b1, 1'b0, 32'h0, 1'b0);
    check("stall_req_count", 32'(req_log.size() - n0), 32'(DEPTH));
    check("stall_frozen_pc", if_id_pc, 32'h0000_1000);
    check("stall_req_low", 32'(imem_req), 32'd0);
    check("req_seq0", req_log[0], 32'h0000_1000);
    check("req_seq1", req_log[1], 32'h0000_1004);
    check("req_seq2", req_log[2], 32'h0000_1008);

    // release: consecutive PCs, no gap or duplicate
    last = BOOT;
    repeat (12) begin
      cycle(1'b0, 1'b0, 32'h0, 1'b0);
      if (if_id_valid) begin
        check("release_order", if_id_pc, last + 32'd4);
        last = if_id_pc;
      end
    end
    check("release_progress", 32'(last > 32'h0000_1010), 32'd1);

    // redirect with nothing outstanding
    wait_idle("idle_before_redirect");
    cycle(1'b0, 1'b1, 32'h0000_0203, 1'b0);
    check("redir_valid", 32'(if_id_valid), 32'd0);
    check("redir_instr", if_id_instr, 32'h0000_0013);
    check("redir_req", 32'(imem_req), 32'd1);
    check("redir_addr", imem_addr, 32'h0000_0200);

    // redirect while a 4-cycle request to 0x100 is pending
    wait_idle("idle_before_drop");
    mem_lat = 4;
    cycle(1'b0, 1'b1, 32'h0000_0100, 1'b0);
    check("drop_setup_addr", imem_addr, 32'h0000_0100);
    cycle(1'b0, 1'b0, 32'h0, 1'b0);
    cycle(1'b0, 1'b1, 32'h0000_0400, 1'b0);
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      check("drop_addr_hold", imem_addr, 32'h0000_0100);
      got = mem_busy && (mem_wait == 0);
      cycle(1'b0, 1'b0, 32'h0, 1'b0);
      check("drop_not_presented", 32'(if_id_valid && if_id_pc == 32'h0000_0100), 32'd0);
    end
    check("drop_ack_seen", 32'(got), 32'd1);
    check("drop_next_req", 32'(imem_req), 32'd1);
    check("drop_next_addr", imem_addr, 32'h0000_0400);

    // redirect, stall and ack in the same cycle with a non-empty FIFO
    mem_lat = 1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (m_q.size() > 0 && mem_busy && mem_wait == 0) got = 1'b1;
      else cycle(1'b1, 1'b0, 32'h0, 1'b0);
    end
    check("triple_setup", 32'(got), 32'd1);
    cycle(1'b1, 1'b1, 32'h0000_0800, 1'b0);
    check("triple_valid", 32'(if_id_valid), 32'd0);
    check("triple_instr", if_id_instr, 32'h0000_0013);
    check("triple_req", 32'(imem_req), 32'd0);
    cycle(1'b1, 1'b0, 32'h0, 1'b0);
    check("triple_next_addr", imem_addr, 32'h0000_0800);

    // reset during S_WAIT
    mem_lat = 4;
    for (int i = 0; i < 20 && !mem_busy; i++) cycle(1'b0, 1'b0, 32'h0, 1'b0);
    check("wait_setup", 32'(mem_busy), 32'd1);
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    check("rst_wait_req", 32'(imem_req), 32'd0);
    check("rst_wait_valid", 32'(if_id_valid), 32'd0);
    cycle(1'b0, 1'b0, 32'h0, 1'b0);
    check("rst_wait_restart", imem_addr, 32'h0000_1000);

    // reset during S_DROP
    cycle(1'b0, 1'b0, 32'h0, 1'b0);
    cycle(1'b0, 1'b1, 32'h0000_0300, 1'b0);
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    check("rst_drop_req", 32'(imem_req), 32'd0);
    check("rst_drop_valid", 32'(if_id_valid), 32'd0);
    cycle(1'b0, 1'b0, 32'h0, 1'b0);
    check("rst_drop_restart_req", 32'(imem_req), 32'd1);
    check("rst_drop_restart", imem_addr, 32'h0000_1000);

    // PC wrap from the top of the address space
    mem_lat = 1;
    wait_idle("idle_before_wrap");
    n0 = req_log.size();
    cycle(1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0);
    check("wrap_first_addr", imem_addr, 32'hFFFF_FFFC);
    for (int i = 0; i < 10 && req_log.size() < n0 + 2; i++) cycle(1'b0, 1'b0, 32'h0, 1'b0);
    check("wrap_log_len", 32'(req_log.size() >= n0 + 2), 32'd1);
    if (req_log.size() >= n0 + 2) check("wrap_to_zero", req_log[n0+1], 32'h0000_0000);

    // randomized traffic
    mem_rand = 1'b1;
    repeat (3000) begin
      cycle($urandom_range(99) < 30, $urandom_range(99) < 4, $urandom(),
            $urandom_range(999) < 3);
    end
    repeat (5) cycle(1'b0, 1'b0, 32'h0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
